// File: rtl/dmem_bus_arbiter_if.sv
// rtl/dmem_bus_arbiter_if.sv - requester and bus signal bundle for dmem_bus_arbiter
interface dmem_bus_arbiter_if;
  logic        p0_req_i;
  logic [31:0] p0_addr_i;
  logic [31:0] p0_wdata_i;
  logic        p0_wen_i;
  logic [3:0]  p0_strb_i;
  logic        p0_done_o;
  logic [31:0] p0_rdata_o;
  logic        p0_err_o;

  logic        p1_req_i;
  logic [31:0] p1_addr_i;
  logic [31:0] p1_wdata_i;
  logic        p1_wen_i;
  logic [3:0]  p1_strb_i;
  logic        p1_done_o;
  logic [31:0] p1_rdata_o;
  logic        p1_err_o;

  logic        bus_valid_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_wen_o;
  logic [3:0]  bus_strb_o;
  logic        bus_ready_i;
  logic [31:0] bus_rdata_i;

  logic [1:0]  grant_o;
  logic        busy_o;

  // The arbiter is the slave of both requesters and drives the shared bus.
  modport slave (
    input  p0_req_i, p0_addr_i, p0_wdata_i, p0_wen_i, p0_strb_i,
    output p0_done_o, p0_rdata_o, p0_err_o,
    input  p1_req_i, p1_addr_i, p1_wdata_i, p1_wen_i, p1_strb_i,
    output p1_done_o, p1_rdata_o, p1_err_o,
    output bus_valid_o, bus_addr_o, bus_wdata_o, bus_wen_o, bus_strb_o,
    input  bus_ready_i, bus_rdata_i,
    output grant_o, busy_o
  );

  modport master (
    output p0_req_i, p0_addr_i, p0_wdata_i, p0_wen_i, p0_strb_i,
    input  p0_done_o, p0_rdata_o, p0_err_o,
    output p1_req_i, p1_addr_i, p1_wdata_i, p1_wen_i, p1_strb_i,
    input  p1_done_o, p1_rdata_o, p1_err_o,
    input  bus_valid_o, bus_addr_o, bus_wdata_o, bus_wen_o, bus_strb_o,
    output bus_ready_i, bus_rdata_i,
    input  grant_o, busy_o
  );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// rtl/dmem_bus_arbiter.sv - round-robin two-port arbiter for a single-outstanding bus
// Optional bus timeout enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk_i,
  input logic               rst_i,
  dmem_bus_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [1:0]  state;
  logic        last_grant;
  logic [1:0]  grant_r;
  logic        busy_r;
  logic        valid_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        wen_r;
  logic [3:0]  strb_r;
  logic [31:0] rdata_r;
  logic [1:0]  done_r;
  logic        pick1;
  logic        in_flight;
  logic        expired;

  // Port 1 wins when it is alone, or when both ask and port 0 was served last.
  always_comb begin
    pick1 = 1'b0;
    if (bus.p1_req_i && (!bus.p0_req_i || !last_grant))
      pick1 = 1'b1;
  end

  assign in_flight = (state == S_ISSUE) || (state == S_WAIT);

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic [1:0]    err_r;

  assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt   <= '0;
      err_r <= 2'b00;
    end else begin
      if (state == S_IDLE)
        cnt <= '0;
      else if (in_flight && !bus.bus_ready_i)
        cnt <= cnt + 1'b1;
      err_r <= (in_flight && !bus.bus_ready_i && expired) ? grant_r : 2'b00;
    end
  end

  assign bus.p0_err_o = err_r[0];
  assign bus.p1_err_o = err_r[1];
`else
  assign expired      = 1'b0;
  assign bus.p0_err_o = 1'b0;
  assign bus.p1_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      grant_r    <= 2'b00;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      wen_r      <= 1'b0;
      strb_r     <= '0;
      rdata_r    <= '0;
      done_r     <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.p0_req_i || bus.p1_req_i) begin
            state      <= S_ISSUE;
            busy_r     <= 1'b1;
            valid_r    <= 1'b1;
            grant_r    <= pick1 ? 2'b10 : 2'b01;
            last_grant <= pick1;
            addr_r     <= pick1 ? bus.p1_addr_i  : bus.p0_addr_i;
            wdata_r    <= pick1 ? bus.p1_wdata_i : bus.p0_wdata_i;
            wen_r      <= pick1 ? bus.p1_wen_i   : bus.p0_wen_i;
            strb_r     <= pick1 ? bus.p1_strb_i  : bus.p0_strb_i;
          end
        end
        S_ISSUE, S_WAIT: begin
          valid_r <= 1'b0;
          if (bus.bus_ready_i) begin
            state   <= S_DONE;
            rdata_r <= bus.bus_rdata_i;
            done_r  <= grant_r;
          end else if (expired) begin
            state   <= S_DONE;
            rdata_r <= '0;
            done_r  <= grant_r;
          end else begin
            state <= S_WAIT;
          end
        end
        default: begin
          state   <= S_IDLE;
          busy_r  <= 1'b0;
          grant_r <= 2'b00;
          rdata_r <= '0;
          done_r  <= 2'b00;
        end
      endcase
    end
  end

  assign bus.p0_done_o  = done_r[0];
  assign bus.p1_done_o  = done_r[1];
  assign bus.p0_rdata_o = rdata_r;
  assign bus.p1_rdata_o = rdata_r;
  assign bus.bus_valid_o = valid_r;
  assign bus.bus_addr_o  = addr_r;
  assign bus.bus_wdata_o = wdata_r;
  assign bus.bus_wen_o   = wen_r;
  assign bus.bus_strb_o  = strb_r;
  assign bus.grant_o     = grant_r;
  assign bus.busy_o      = busy_r;

endmodule
